// File: rtl/router_pkg.sv
// router_pkg: flit types and head-flit layout shared by segment_pkt and reassembly_pkt
package router_pkg;
  localparam int ADDR_W = 10;
  localparam int DFX_W  = 2;
  localparam int SEQ_W  = 4;
  localparam int HDR_W  = 2*DFX_W + 2*ADDR_W + SEQ_W;
  localparam int HDR_SRC_DFX_OFF  = HDR_W - DFX_W;
  localparam int HDR_DST_DFX_OFF  = HDR_SRC_DFX_OFF - DFX_W;
  localparam int HDR_SRC_ADDR_OFF = HDR_DST_DFX_OFF - ADDR_W;
  localparam int HDR_DST_ADDR_OFF = HDR_SRC_ADDR_OFF - ADDR_W;
  localparam int HDR_SEQ_OFF      = 0;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10
  } flit_type_e;

  // Header occupies the top HDR_W bits of the head flit; offsets are within the header field.
  function automatic logic [HDR_W-1:0] pack_hdr(
    input logic [DFX_W-1:0]  src_dfx,
    input logic [DFX_W-1:0]  dst_dfx,
    input logic [ADDR_W-1:0] src_addr,
    input logic [ADDR_W-1:0] dst_addr,
    input logic [SEQ_W-1:0]  seq
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SRC_DFX_OFF  +: DFX_W]  = src_dfx;
    h[HDR_DST_DFX_OFF  +: DFX_W]  = dst_dfx;
    h[HDR_SRC_ADDR_OFF +: ADDR_W] = src_addr;
    h[HDR_DST_ADDR_OFF +: ADDR_W] = dst_addr;
    h[HDR_SEQ_OFF      +: SEQ_W]  = seq;
    return h;
  endfunction
endpackage

// File: rtl/segment_pkt_ack_timer.sv
// seg_ack_timer: ack timeout counter and retransmission counter
module seg_ack_timer #(
  parameter int ACK_TIMEOUT = 256,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  input  logic retry_i,
  output logic expired_o,
  output logic exhausted_o
);
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RTY_W-1:0] retry_q, retry_d;

  // Timer runs only while waiting for an ack and sits at zero otherwise.
  always_comb begin
    timer_d = enable_i ? timer_q + 1'b1 : '0;
    retry_d = clear_i ? '0 : retry_i ? retry_q + 1'b1 : retry_q;
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  assign expired_o   = enable_i && timer_q == TMR_W'(ACK_TIMEOUT - 1);
  assign exhausted_o = retry_q >= RTY_W'(MAX_RETRY);
endmodule

// File: rtl/segment_pkt.sv
// segment_pkt: splits one request into head + body flits and retransmits until acknowledged
module segment_pkt
  import router_pkg::*;
#(
  parameter int DATA_W      = 1024,
  parameter int FLIT_W      = 64,
  parameter int ACK_TIMEOUT = 256,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_src_addr,
  input  logic [ADDR_W-1:0] in_dst_addr,
  input  logic [DFX_W-1:0]  in_src_dfx,
  input  logic [DFX_W-1:0]  in_dst_dfx,
  input  logic [DATA_W-1:0] in_data,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [1:0]        flit_type,
  output logic [FLIT_W-1:0] flit_data,
  input  logic              ack_valid,
  input  logic              ack_ok,
  input  logic [SEQ_W-1:0]  ack_seq,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int N     = DATA_W / FLIT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_WAIT_ACK} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] src_addr_q, dst_addr_q;
  logic [DFX_W-1:0]  src_dfx_q, dst_dfx_q;
  logic [DATA_W-1:0] data_q;
  logic              load, tmr_clear, tmr_retry, expired, exhausted;
  logic              ack_match, tail, in_head, in_body;

  assign in_head   = state_q == S_HEAD;
  assign in_body   = state_q == S_BODY;
  assign tail      = idx_q == IDX_W'(N - 1);
  assign ack_match = ack_valid && ack_seq == seq_q;

  seg_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (tmr_clear),
    .enable_i    (state_q == S_WAIT_ACK),
    .retry_i     (tmr_retry),
    .expired_o   (expired),
    .exhausted_o (exhausted)
  );

  // Next state: a matching ACK takes priority over a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load      = 1'b0;
    tmr_clear = 1'b0;
    tmr_retry = 1'b0;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        load      = 1'b1;
        tmr_clear = 1'b1;
        state_d   = S_HEAD;
      end
      S_HEAD: begin
        idx_d = '0;
        if (flit_ready) state_d = S_BODY;
      end
      S_BODY: if (flit_ready) begin
        idx_d = idx_q + 1'b1;
        if (tail) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (ack_match && ack_ok) begin
        done_d  = 1'b1;
        seq_d   = seq_q + 1'b1;
        state_d = S_IDLE;
      end else if (ack_match || expired) begin
        if (!exhausted) begin
          tmr_retry = 1'b1;
          state_d   = S_HEAD;
        end else begin
          err_d   = 1'b1;
          seq_d   = seq_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; reset aborts any packet in flight without a done/err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Hold buffer keeps the request for retransmission and survives reset.
  always_ff @(posedge clk) begin
    if (load) begin
      src_addr_q <= in_src_addr;
      dst_addr_q <= in_dst_addr;
      src_dfx_q  <= in_src_dfx;
      dst_dfx_q  <= in_dst_dfx;
      data_q     <= in_data;
    end
  end

  assign in_ready   = state_q == S_IDLE;
  assign busy       = !in_ready;
  assign flit_valid = in_head || in_body;
  assign flit_type  = in_head ? FLIT_HEAD : (in_body && tail) ? FLIT_TAIL : FLIT_BODY;
  assign flit_data  = in_head ? {pack_hdr(src_dfx_q, dst_dfx_q, src_addr_q, dst_addr_q, seq_q), {(FLIT_W-HDR_W){1'b0}}}
                    : in_body ? data_q[idx_q*FLIT_W +: FLIT_W] : '0;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_segment_pkt.sv
// tb_segment_pkt: randomized self-checking bench for segment_pkt against a packet-level model
module tb_segment_pkt;
  localparam int AT = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    in_src_addr = '0, in_dst_addr = '0;
  logic [1:0]    in_src_dfx = '0, in_dst_dfx = '0;
  logic [1023:0] in_data = '0;
  logic          flit_valid;
  logic          flit_ready = 1'b0;
  logic [1:0]    flit_type;
  logic [63:0]   flit_data;
  logic          ack_valid = 1'b0, ack_ok = 1'b0;
  logic [3:0]    ack_seq = '0;
  logic          busy, done, err;

  always #5 clk = ~clk;

  segment_pkt #(.DATA_W(1024), .FLIT_W(64), .ACK_TIMEOUT(AT), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_src_addr(in_src_addr), .in_dst_addr(in_dst_addr),
    .in_src_dfx(in_src_dfx), .in_dst_dfx(in_dst_dfx), .in_data(in_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_type(flit_type), .flit_data(flit_data),
    .ack_valid(ack_valid), .ack_ok(ack_ok), .ack_seq(ack_seq),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [9:0]    src;
    logic [9:0]    dst;
    logic [1:0]    sdfx;
    logic [1:0]    ddfx;
    logic [1023:0] data;
  } req_t;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] exp_seq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Flit k of a packet: 0 is the head, 1..N are body words lowest first, the last one is the tail.
  function automatic logic [65:0] exp_flit(input req_t r, input logic [3:0] s, input int k);
    if (k == 0) return {2'b01, r.sdfx, r.ddfx, r.src, r.dst, s, 36'b0};
    return {(k == N) ? 2'b10 : 2'b00, r.data[(k-1)*64 +: 64]};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.src  = 10'($urandom);
    r.dst  = 10'($urandom);
    r.sdfx = 2'($urandom);
    r.ddfx = 2'($urandom);
    for (int i = 0; i < 32; i++) r.data[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic issue(input req_t r);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_src_addr = r.src;
    in_dst_addr = r.dst;
    in_src_dfx = r.sdfx;
    in_dst_dfx = r.ddfx;
    in_data = r.data;
    tick;
    in_valid = 1'b0;
    in_src_addr = ~r.src;
    in_dst_addr = ~r.dst;
    in_data = ~r.data;
    check("busy_after_accept", busy, 1);
    check("in_ready_busy", in_ready, 0);
  endtask

  // mode 0: ready always, 1: ready alternating 1010..., 2: random ready
  task automatic collect(input req_t r, input logic [3:0] s, input int mode, input int nflits, output int cyc);
    int k;
    logic [65:0] e;
    k = 0;
    cyc = 0;
    while (k < nflits && cyc < 400) begin
      flit_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
      e = exp_flit(r, s, k);
      check("flit_valid", flit_valid, 1);
      check($sformatf("flit_type[%0d]", k), flit_type, e[65:64]);
      check($sformatf("flit_data[%0d]", k), flit_data, e[63:0]);
      if (flit_ready) k++;
      cyc++;
      tick;
    end
    flit_ready = 1'b0;
    if (k < nflits) check("flit_budget", k, nflits);
  endtask

  task automatic send_ack(input logic [3:0] s, input logic ok);
    ack_valid = 1'b1;
    ack_seq = s;
    ack_ok = ok;
    tick;
    ack_valid = 1'b0;
    ack_seq = 4'($urandom);
    ack_ok = 1'($urandom);
  endtask

  // what 0: wait for a resent head, 1: wait for err
  task automatic wait_for(input int what, output int n);
    n = 0;
    while (!((what == 0) ? flit_valid : err) && n < 50) begin
      tick;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int cyc, n, mode, act, d, retries;
    logic junk, fin;
    tick;
    tick;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_type", flit_type, 0);
    check("rst_flit_data", flit_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    exp_seq = 4'd0;

    send_ack(4'd0, 1'b1);
    check("idle_ack_done", done, 0);
    check("idle_ack_busy", busy, 0);

    r.src = 10'h001;
    r.dst = 10'h005;
    r.sdfx = 2'b01;
    r.ddfx = 2'b10;
    for (int k = 0; k < N; k++) r.data[k*64 +: 64] = 64'(k);
    issue(r);
    collect(r, exp_seq, 0, N + 1, cyc);
    check("latency_ready_high", cyc, N + 1);
    check("wait_flit_valid", flit_valid, 0);
    send_ack(exp_seq, 1'b1);
    check("basic_done", done, 1);
    check("basic_err", err, 0);
    check("basic_in_ready", in_ready, 1);
    exp_seq++;
    tick;
    check("done_one_cycle", done, 0);

    r = rand_req();
    issue(r);
    collect(r, exp_seq, 1, N + 1, cyc);
    check("latency_backpressure", cyc, 2 * N + 1);
    send_ack(exp_seq + 4'd3, 1'b1);
    check("mismatch_done", done, 0);
    check("mismatch_busy", busy, 1);
    check("mismatch_flit_valid", flit_valid, 0);
    send_ack(exp_seq, 1'b0);
    check("nack_resend", flit_valid, 1);
    check("nack_err", err, 0);
    collect(r, exp_seq, 0, N + 1, cyc);
    repeat (AT - 1) tick;
    send_ack(exp_seq, 1'b1);
    check("race_done", done, 1);
    check("race_no_resend", flit_valid, 0);
    check("race_in_ready", in_ready, 1);
    exp_seq++;
    tick;

    r = rand_req();
    issue(r);
    for (int s = 0; s < 4; s++) begin
      collect(r, exp_seq, 2, N + 1, cyc);
      if (s < 3) begin
        wait_for(0, n);
        check("timeout_resend_cycles", n, AT);
      end else begin
        wait_for(1, n);
        check("timeout_err_cycles", n, AT);
        check("exhaust_in_ready", in_ready, 1);
        check("exhaust_done", done, 0);
      end
    end
    exp_seq++;
    tick;
    check("err_one_cycle", err, 0);

    r = rand_req();
    issue(r);
    collect(r, exp_seq, 0, 6, cyc);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_flit_valid", flit_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    exp_seq = 4'd0;
    tick;
    check("abort_done_later", done, 0);
    check("abort_err_later", err, 0);
    r = rand_req();
    issue(r);
    collect(r, exp_seq, 0, N + 1, cyc);
    send_ack(exp_seq, 1'b1);
    check("after_abort_done", done, 1);
    exp_seq++;
    tick;

    for (int p = 0; p < 20; p++) begin
      r = rand_req();
      mode = $urandom % 3;
      issue(r);
      retries = 0;
      fin = 1'b0;
      while (!fin) begin
        collect(r, exp_seq, mode, N + 1, cyc);
        check("rand_wait_flit_valid", flit_valid, 0);
        act = $urandom % 4;
        if (act < 2) begin
          d = $urandom % AT;
          junk = 1'($urandom % 2);
          for (int i = 0; i < d; i++) begin
            ack_valid = (i == 0) && junk;
            ack_seq = exp_seq + 4'(1 + $urandom % 15);
            ack_ok = 1'($urandom);
            tick;
            ack_valid = 1'b0;
            check("rand_junk_done", done, 0);
            check("rand_junk_flit_valid", flit_valid, 0);
          end
          send_ack(exp_seq, 1'b1);
          check("rand_done", done, 1);
          check("rand_done_err", err, 0);
          exp_seq++;
          fin = 1'b1;
        end else begin
          if (act == 2) send_ack(exp_seq, 1'b0);
          else begin
            wait_for((retries < 3) ? 0 : 1, n);
            check("rand_timeout_cycles", n, AT);
          end
          if (retries < 3) begin
            check("rand_retry_flit_valid", flit_valid, 1);
            retries++;
          end else begin
            check("rand_exhaust_err", err, 1);
            check("rand_exhaust_done", done, 0);
            exp_seq++;
            fin = 1'b1;
          end
        end
      end
      tick;
      check("rand_idle_done", done, 0);
      check("rand_idle_err", err, 0);
      check("rand_idle_in_ready", in_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/segment_pkt.md
# segment_pkt

Source-side packetizer feeding the 4-lane router, the mirror stage of `reassembly_pkt`. It captures one request (10-bit source and destination addresses, 2-bit source and destination DFX IDs, 1024-bit payload) and emits it as one head flit plus DATA_W/FLIT_W body flits over a valid/ready flit port. It then holds the packet until the destination acknowledges it, retransmitting on NACK or timeout up to MAX_RETRY times.

## Interface
- DATA_W, 1024: payload width.
- ADDR_W, 10: router address width.
- DFX_W, 2: DFX region ID width.
- FLIT_W, 64: flit payload width. Must divide DATA_W.
- ACK_TIMEOUT, 256: cycles spent in WAIT_ACK before a retry.
- MAX_RETRY, 3: retransmissions allowed after the first send.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid / in_ready  in / out  1  request handshake.
- in_src_addr, in_dst_addr  in  ADDR_W  request addresses.
- in_src_dfx, in_dst_dfx  in  DFX_W  request DFX IDs.
- in_data  in  DATA_W  request payload.
- flit_valid / flit_ready  out / in  1  flit handshake.
- flit_type  out  2  flit type: 01 head, 00 body, 10 tail.
- flit_data  out  FLIT_W  flit payload.
- ack_valid  in  1  acknowledge strobe.
- ack_ok  in  1  1 = ACK, 0 = NACK.
- ack_seq  in  4  sequence number being acknowledged.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful delivery.
- err  out  1  one-cycle pulse when retries are exhausted.

## Operation
- States: IDLE, HEAD, BODY, WAIT_ACK.
- **IDLE**
  - in_ready=1.
  - When in_valid && in_ready, all request fields are latched into a hold buffer, retry_cnt is cleared, and the FSM moves to HEAD.
- **HEAD**
  - Drives flit_type=01.
  - flit_data = {in_src_dfx, in_dst_dfx, in_src_addr, in_dst_addr, seq[3:0], zero pad}, MSB first.
- **BODY**
  - Body flit k (k = 0 .. N-1, where N = DATA_W/FLIT_W) carries data[k*FLIT_W +: FLIT_W], lowest word first.
  - Flit N-1 is typed 10 (tail). All other body flits are typed 00.
- **Flit port rules**
  - flit_valid=1 throughout HEAD and BODY.
  - flit_type and flit_data stay stable until flit_ready is sampled high.
  - flit_valid never drops while a flit is pending.
  - When the tail is accepted, the FSM moves to WAIT_ACK and the timer is cleared.
- **WAIT_ACK**
  - The timer counts up by 1 each cycle.
  - ack_valid && ack_seq==seq && ack_ok: done pulses, seq increments modulo 16, FSM returns to IDLE.
  - Matching NACK, or timer reaching ACK_TIMEOUT-1 with no ack:
    - if retry_cnt < MAX_RETRY: retry_cnt++, resend from HEAD using the hold buffer, same seq;
    - otherwise: err pulses, seq increments, FSM returns to IDLE.
- **Boundary conditions**
  - An ack whose seq does not match is ignored.
  - An ack outside WAIT_ACK is ignored.
  - If a matching ack arrives in the same cycle the timeout expires, the ack wins.
  - in_valid is ignored while busy. in_ready is 0 in every state except IDLE.
  - rst asserted mid-packet aborts the packet: the FSM returns to IDLE on the next edge, the hold buffer is not cleared, and no done or err is produced.

## Timing
- **Reset values:** in_ready=1, flit_valid=0, flit_type=00, flit_data=0, busy=0, done=0, err=0, seq=0, retry_cnt=0, timer=0.
- **Packet latency:**
  - Request accepted at edge T.
  - Head flit valid from T+1.
  - With flit_ready held high, the tail (N=16) is accepted at edge T+17 and WAIT_ACK starts at T+17.
  - Total is N+1 cycles per send.
- **Ack latency:** ack sampled at edge A; done/err high during cycle A+1; in_ready high from A+1.
- **Back-to-back:** IDLE is occupied for at least one cycle between packets.
- **Retry:** the head flit is re-presented in the cycle after the NACK or timeout edge.

## Structure
- **Shared package `router_pkg`:**
  - flit type enum (HEAD / BODY / TAIL);
  - ADDR_W and DFX_W;
  - header field offsets and seq width, shared with `reassembly_pkt` so both stages agree on the head-flit layout.
- **Sub-module `seg_ack_timer`:** timeout counter plus retry counter, with inputs clear, enable and retry and outputs expired and exhausted.
- **Top level:** FSM, hold buffer, body-word mux driven by a log2(N)-bit flit index.

## Test plan
- **Basic send:** request src=0x001, dst=0x005, src_dfx=01, dst_dfx=10, data = word index in each 64-bit lane, flit_ready=1 → head flit, then 16 body flits with body k = k and the last typed 10; ACK seq=0 → done pulse one cycle later, next packet uses seq=1.
- **Backpressure:** flit_ready toggles 1010… → every flit is held stable while stalled, no flit is dropped or duplicated, and the tail is accepted after 33 cycles.
- **NACK retry:** NACK seq=0 → identical 17-flit packet resent with seq=0; ACK → done.
- **Timeout exhaustion:** ACK_TIMEOUT=8 and no ack ever sent → 4 sends in total (first plus 3 retries), then an err pulse, seq=1, FSM back in IDLE.
- **Ack races:**
  - ack with seq=3 while seq=0 → ignored;
  - matching ACK in the same cycle the timer expires → done, no resend.
- **Mid-packet reset:** rst asserted for 1 cycle after the 5th body flit → flit_valid=0 and in_ready=1 from the next cycle, seq=0, and the following request sends a clean packet.
